seq_checker: RTL
================

SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 Parameter WIDTH, default 8, sample width in bits.
REQ-002 Parameter LOCK_N, default 4, consecutive in-sequence samples required to lock (range 2..15).
REQ-003 Parameter LOSE_N, default 3, consecutive mismatches while locked that drop lock (range 1..15).
REQ-004 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port in_valid  input  1  in_data holds a sample this cycle.
REQ-007 Port in_data  input  WIDTH  sample from the upstream free-running counter.
REQ-008 Port err_clr  input  1  synchronous clear of err_count.
REQ-009 Port locked  output  1  checker is tracking the sequence.
REQ-010 Port err  output  1  one-cycle pulse per mismatched sample while locked.
REQ-011 Port err_count  output  16  saturating mismatch count.
REQ-012 Port expect_data  output  WIDTH  next value the checker expects.

Function
REQ-013 The checker SHALL have two states, HUNT and LOCKED, plus internal counters run (4 bits) and miss (4 bits) and a have_prev flag.
REQ-014 All outputs SHALL be registered; the effect of a sample accepted in cycle N SHALL be visible in cycle N+1.
REQ-015 Cycles with in_valid=0 SHALL change no state other than err_count via err_clr, and SHALL hold err low.
REQ-016 Increment arithmetic SHALL be modulo 2^WIDTH; 2^WIDTH-1 followed by 0 is in sequence.
REQ-017 HUNT, valid, have_prev=0: run<=1, have_prev<=1, expect_data<=in_data+1.
REQ-018 HUNT, valid, in_data==expect_data: run<=run+1, expect_data<=in_data+1; if run+1==LOCK_N then state<=LOCKED, miss<=0.
REQ-019 HUNT, valid, mismatch: run<=1, expect_data<=in_data+1 (reseed); err SHALL NOT assert and err_count SHALL NOT change in HUNT.
REQ-020 LOCKED, valid, match: expect_data<=expect_data+1, miss<=0.
REQ-021 LOCKED, valid, mismatch: err pulses, err_count increments, miss<=miss+1, expect_data<=expect_data+1 (flywheel).
REQ-022 LOCKED, mismatch with miss+1==LOSE_N: state<=HUNT, run<=1, expect_data<=in_data+1; err still pulses for this sample.
REQ-023 locked SHALL equal (state==LOCKED).
REQ-024 err_count SHALL saturate at 16'hFFFF and never wrap.
REQ-025 err_clr SHALL take precedence over a simultaneous increment: err_count<=0 and that cycle's mismatch is not counted (err still pulses).

Reset
REQ-026 While rst=1 at a clock edge: state<=HUNT, run<=0, miss<=0, have_prev<=0, expect_data<=0, locked<=0, err<=0, err_count<=0.
REQ-027 rst SHALL override in_valid and err_clr in the same cycle; the sample is discarded.
REQ-028 Reset asserted mid-lock SHALL fully restart acquisition; no state survives.

Structure
REQ-029 A shared package seq_chk_pkg SHALL hold the state encoding (HUNT=0, LOCKED=1) and the err_count width constant (16).
REQ-030 The saturating counter SHALL be one sub-module, sat_counter (inputs clk, rst, clr, inc; output count); the FSM stays in seq_checker.

Verification
REQ-031 Reset, then feed 10,11,12,13 on consecutive valid cycles -> locked=1 in the cycle after 13, expect_data=14, err_count=0.
REQ-032 Locked at expect 0xFE, feed 0xFE,0xFF,0x00,0x01 -> no err, locked stays 1, expect_data=0x02.
REQ-033 Locked at expect 20, feed 20,99,22,23 -> single err pulse after 99, err_count=1, locked stays 1, expect_data=24.
REQ-034 Locked, feed 3 consecutive wrong values 50,60,70 (LOSE_N=3) -> 3 err pulses, err_count=3, locked=0 after 70, expect_data=71; then 71,72,73 -> relock after 73.
REQ-035 err_count preloaded to 0xFFFF via 65535 mismatches (or forced), one more mismatch -> stays 0xFFFF; err_clr with simultaneous mismatch -> err_count=0, err=1.
REQ-036 Locked, gaps of in_valid=0 between 5,6,7 -> no state change during gaps; rst=1 mid-stream -> next cycle locked=0, err_count=0, expect_data=0.

Source files
------------

// File: rtl/seq_chk_pkg.sv
// Shared definitions for the sequence checker: FSM state encoding and
// error-counter width.
package seq_chk_pkg;

  typedef enum logic {
    StHunt   = 1'b0,
    StLocked = 1'b1
  } seq_state_e;

  localparam int unsigned ErrCountW = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
  import seq_chk_pkg::*;
#(
  parameter int unsigned Width = ErrCountW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {Width{1'b1}})) begin
      count_d = count_q + {{(Width-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_checker.sv
// Locks onto an incrementing counter stream, flags mismatches while locked
// and keeps a saturating count of them.
module seq_checker
  import seq_chk_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned LOSE_N = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 err_clr,
  output logic                 locked,
  output logic                 err,
  output logic [ErrCountW-1:0] err_count,
  output logic [WIDTH-1:0]     expect_data
);

  localparam logic [WIDTH-1:0] One   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]       LockN = 4'(LOCK_N);
  localparam logic [3:0]       LoseN = 4'(LOSE_N);

  seq_state_e       state_d, state_q;
  logic [3:0]       run_d, run_q;
  logic [3:0]       miss_d, miss_q;
  logic             have_prev_d, have_prev_q;
  logic [WIDTH-1:0] expect_d, expect_q;
  logic             err_d, err_q;

  logic [3:0] run_inc, miss_inc;
  logic       match;

  assign run_inc  = run_q + 4'd1;
  assign miss_inc = miss_q + 4'd1;
  assign match    = (in_data == expect_q);

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    miss_d      = miss_q;
    have_prev_d = have_prev_q;
    expect_d    = expect_q;
    err_d       = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        StHunt: begin
          // Every hunting sample reseeds the expectation from itself.
          have_prev_d = 1'b1;
          expect_d    = in_data + One;
          if (have_prev_q && match) begin
            run_d = run_inc;
            if (run_inc == LockN) begin
              state_d = StLocked;
              miss_d  = '0;
            end
          end else begin
            run_d = 4'd1;
          end
        end
        StLocked: begin
          if (match) begin
            expect_d = expect_q + One;
            miss_d   = '0;
          end else begin
            err_d  = 1'b1;
            miss_d = miss_inc;
            if (miss_inc == LoseN) begin
              state_d  = StHunt;
              run_d    = 4'd1;
              expect_d = in_data + One;
            end else begin
              // Flywheel: keep counting as if the sample had been correct.
              expect_d = expect_q + One;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StHunt;
      run_q       <= '0;
      miss_q      <= '0;
      have_prev_q <= 1'b0;
      expect_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      have_prev_q <= have_prev_d;
      expect_q    <= expect_d;
      err_q       <= err_d;
    end
  end

  sat_counter #(
    .Width(ErrCountW)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (err_clr),
    .inc  (err_d),
    .count(err_count)
  );

  assign locked      = (state_q == StLocked);
  assign err         = err_q;
  assign expect_data = expect_q;

endmodule
